// File: rtl/jtframe_vidgen.sv
// Programmable video timing generator: H/V counters plus registered blanking and sync.
// Optional raster interrupt is built only when JTFRAME_VIDGEN_IRQ_EN is defined.
module jtframe_vidgen #(
    parameter int CNTW     = 10,
    parameter int HTOTAL   = 384,
    parameter int HB_START = 256,
    parameter int HB_END   = 0,
    parameter int HS_START = 288,
    parameter int HS_END   = 320,
    parameter int VTOTAL   = 264,
    parameter int VB_START = 240,
    parameter int VB_END   = 16,
    parameter int VS_START = 244,
    parameter int VS_END   = 248
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pxl_cen,
    output logic [CNTW-1:0] H,
    output logic [CNTW-1:0] V,
    output logic            LHBL,
    output logic            LVBL,
    output logic            HS,
    output logic            VS,
    output logic            frame,
    input  logic [CNTW-1:0] irq_line,
    input  logic            irq_ack,
    output logic            irq
);

    localparam logic [CNTW-1:0] L_HLAST = CNTW'(HTOTAL - 1);
    localparam logic [CNTW-1:0] L_VLAST = CNTW'(VTOTAL - 1);
    localparam logic [CNTW-1:0] L_HBS   = CNTW'(HB_START);
    localparam logic [CNTW-1:0] L_HBE   = CNTW'(HB_END);
    localparam logic [CNTW-1:0] L_HSS   = CNTW'(HS_START);
    localparam logic [CNTW-1:0] L_HSE   = CNTW'(HS_END);
    localparam logic [CNTW-1:0] L_VBS   = CNTW'(VB_START);
    localparam logic [CNTW-1:0] L_VBE   = CNTW'(VB_END);
    localparam logic [CNTW-1:0] L_VSS   = CNTW'(VS_START);
    localparam logic [CNTW-1:0] L_VSE   = CNTW'(VS_END);

    // A window with start > end wraps through zero; start == end is empty.
    function automatic logic f_win(input logic [CNTW-1:0] c,
                                   input logic [CNTW-1:0] s,
                                   input logic [CNTW-1:0] e);
        if (s < e)
            f_win = (c >= s) && (c < e);
        else if (s > e)
            f_win = (c >= s) || (c < e);
        else
            f_win = 1'b0;
    endfunction

    logic [CNTW-1:0] r_h, r_v;
    logic            r_lhbl, r_lvbl, r_hs, r_vs, r_frame;
    logic [CNTW-1:0] w_hn, w_vn;
    logic            w_hwrap, w_vwrap;

    always_comb begin
        w_hn    = r_h + 1'b1;
        w_vn    = r_v;
        w_hwrap = 1'b0;
        w_vwrap = 1'b0;
        if (r_h == L_HLAST) begin
            w_hn    = '0;
            w_hwrap = 1'b1;
            if (r_v == L_VLAST) begin
                w_vn    = '0;
                w_vwrap = 1'b1;
            end else begin
                w_vn = r_v + 1'b1;
            end
        end
    end

    // Status flags are decoded from the next counter values so they line up with H/V.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_h     <= '0;
            r_v     <= '0;
            r_frame <= 1'b0;
            r_lhbl  <= ~f_win('0, L_HBS, L_HBE);
            r_hs    <=  f_win('0, L_HSS, L_HSE);
            r_lvbl  <= ~f_win('0, L_VBS, L_VBE);
            r_vs    <=  f_win('0, L_VSS, L_VSE);
        end else if (pxl_cen) begin
            r_h     <= w_hn;
            r_v     <= w_vn;
            r_frame <= r_frame ^ w_vwrap;
            r_lhbl  <= ~f_win(w_hn, L_HBS, L_HBE);
            r_hs    <=  f_win(w_hn, L_HSS, L_HSE);
            r_lvbl  <= ~f_win(w_vn, L_VBS, L_VBE);
            r_vs    <=  f_win(w_vn, L_VSS, L_VSE);
        end
    end

    assign H     = r_h;
    assign V     = r_v;
    assign LHBL  = r_lhbl;
    assign LVBL  = r_lvbl;
    assign HS    = r_hs;
    assign VS    = r_vs;
    assign frame = r_frame;

`ifdef JTFRAME_VIDGEN_IRQ_EN
    logic r_irq;

    // Setting has priority over an acknowledge on the same edge.
    always_ff @(posedge clk) begin
        if (rst)
            r_irq <= 1'b0;
        else if (pxl_cen && w_hwrap && (w_vn == irq_line))
            r_irq <= 1'b1;
        else if (irq_ack)
            r_irq <= 1'b0;
    end

    assign irq = r_irq;
`else
    logic w_unused_irq;
    assign w_unused_irq = ^{irq_line, irq_ack};
    assign irq          = 1'b0;
`endif

endmodule

// File: tb/tb_jtframe_vidgen.sv
// Scoreboard bench for jtframe_vidgen: three instances (default, scaled, empty-HBLANK)
// run in lockstep; a reference model queues expected outputs, a monitor compares them.
module tb_jtframe_vidgen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, cen = 1'b0, ack = 1'b0;
    logic [9:0] il_a = 10'd100, il_b = 10'd5, il_c = 10'd300;

    logic [9:0] h_a, v_a, h_b, v_b, h_c, v_c;
    logic lhbl_a, lvbl_a, hs_a, vs_a, fr_a, irq_a;
    logic lhbl_b, lvbl_b, hs_b, vs_b, fr_b, irq_b;
    logic lhbl_c, lvbl_c, hs_c, vs_c, fr_c, irq_c;

    jtframe_vidgen u_a (
        .clk(clk), .rst(rst), .pxl_cen(cen), .H(h_a), .V(v_a),
        .LHBL(lhbl_a), .LVBL(lvbl_a), .HS(hs_a), .VS(vs_a), .frame(fr_a),
        .irq_line(il_a), .irq_ack(ack), .irq(irq_a)
    );

    jtframe_vidgen #(
        .HTOTAL(24), .HB_START(16), .HB_END(0), .HS_START(18), .HS_END(21),
        .VTOTAL(20), .VB_START(15), .VB_END(3), .VS_START(16), .VS_END(18)
    ) u_b (
        .clk(clk), .rst(rst), .pxl_cen(cen), .H(h_b), .V(v_b),
        .LHBL(lhbl_b), .LVBL(lvbl_b), .HS(hs_b), .VS(vs_b), .frame(fr_b),
        .irq_line(il_b), .irq_ack(ack), .irq(irq_b)
    );

    jtframe_vidgen #(
        .HTOTAL(24), .HB_START(10), .HB_END(10), .HS_START(18), .HS_END(21),
        .VTOTAL(20), .VB_START(15), .VB_END(3), .VS_START(16), .VS_END(18)
    ) u_c (
        .clk(clk), .rst(rst), .pxl_cen(cen), .H(h_c), .V(v_c),
        .LHBL(lhbl_c), .LVBL(lvbl_c), .HS(hs_c), .VS(vs_c), .frame(fr_c),
        .irq_line(il_c), .irq_ack(ack), .irq(irq_c)
    );

`ifdef JTFRAME_VIDGEN_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
        logic lhbl, lvbl, hs, vs, frame, irq;
    } obs_t;

    typedef struct {
        obs_t e;
        bit   cen;
        bit   rst;
    } item_t;

    obs_t act[3];
    assign act[0] = {h_a, v_a, lhbl_a, lvbl_a, hs_a, vs_a, fr_a, irq_a};
    assign act[1] = {h_b, v_b, lhbl_b, lvbl_b, hs_b, vs_b, fr_b, irq_b};
    assign act[2] = {h_c, v_c, lhbl_c, lvbl_c, hs_c, vs_c, fr_c, irq_c};

    // Timing tables for instances a, b, c.
    int HT[3]  = '{384, 24, 24};
    int HBS[3] = '{256, 16, 10};
    int HBE[3] = '{0,   0,  10};
    int HSS[3] = '{288, 18, 18};
    int HSE[3] = '{320, 21, 21};
    int VT[3]  = '{264, 20, 20};
    int VBS[3] = '{240, 15, 15};
    int VBE[3] = '{16,  3,  3};
    int VSS[3] = '{244, 16, 16};
    int VSE[3] = '{248, 18, 18};
    int IL[3]  = '{100, 5,  300};

    int mh[3], mv[3];
    bit mf[3], mi[3];
    item_t sb[3][$];

    int n_chk = 0, n_err = 0;

    function automatic bit win(int c, int s, int e);
        if (s < e) return (c >= s) && (c < e);
        if (s > e) return (c >= s) || (c < e);
        return 1'b0;
    endfunction

    function automatic obs_t decode(int d);
        obs_t o;
        o.h     = 10'(mh[d]);
        o.v     = 10'(mv[d]);
        o.lhbl  = !win(mh[d], HBS[d], HBE[d]);
        o.hs    =  win(mh[d], HSS[d], HSE[d]);
        o.lvbl  = !win(mv[d], VBS[d], VBE[d]);
        o.vs    =  win(mv[d], VSS[d], VSE[d]);
        o.frame = mf[d];
        o.irq   = mi[d];
        return o;
    endfunction

    task automatic model_step(int d, bit c, bit r, bit a);
        if (r) begin
            mh[d] = 0; mv[d] = 0; mf[d] = 1'b0; mi[d] = 1'b0;
        end else begin
            if (c) begin
                if (mh[d] == HT[d] - 1) begin
                    mh[d] = 0;
                    if (mv[d] == VT[d] - 1) begin
                        mv[d] = 0;
                        mf[d] = !mf[d];
                    end else begin
                        mv[d] = mv[d] + 1;
                    end
                end else begin
                    mh[d] = mh[d] + 1;
                end
            end
            if (IRQ_EN && c && mh[d] == 0 && mv[d] == IL[d]) mi[d] = 1'b1;
            else if (a) mi[d] = 1'b0;
        end
    endtask

    task automatic step(bit c, bit r, bit a);
        item_t it;
        @(negedge clk);
        cen = c; rst = r; ack = a;
        for (int d = 0; d < 3; d++) begin
            model_step(d, c, r, a);
            it.e = decode(d); it.cen = c; it.rst = r;
            sb[d].push_back(it);
        end
    endtask

    task automatic cmp(string nm, int d, logic [31:0] a, logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s dut%0d: got %0d expected %0d at %0t", nm, d, a, e, $time);
        end
    endtask

    // Monitor: pops one expectation per instance after every clock edge.
    int a_hs = 0, a_lb = 0, a_lines = 0, b_cnt = 0, b_frames = 0, c_lb = 0;
    logic [9:0] a_prevh = '0;
    logic b_fr = 1'b0;
    obs_t prev[3];

    initial begin
        item_t it;
        forever begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 3; d++) begin
                if (sb[d].size() > 0) begin
                    it = sb[d].pop_front();
                    cmp("H", d, act[d].h, it.e.h);
                    cmp("V", d, act[d].v, it.e.v);
                    cmp("LHBL", d, act[d].lhbl, it.e.lhbl);
                    cmp("LVBL", d, act[d].lvbl, it.e.lvbl);
                    cmp("HS", d, act[d].hs, it.e.hs);
                    cmp("VS", d, act[d].vs, it.e.vs);
                    cmp("frame", d, act[d].frame, it.e.frame);
                    cmp("irq", d, act[d].irq, it.e.irq);
                    if (d == 0 && (it.rst || it.cen)) begin
                        if (it.rst) begin
                            a_hs = 0; a_lb = 0;
                        end else if (act[0].h == 10'd0 && a_prevh == 10'd383) begin
                            cmp("hs_pixels_per_line", 0, a_hs, 32);
                            cmp("hblank_pixels_per_line", 0, a_lb, 128);
                            a_lines++;
                            a_hs = 0; a_lb = 0;
                        end
                        if (act[0].hs) a_hs++;
                        if (!act[0].lhbl) a_lb++;
                        a_prevh = act[0].h;
                    end
                    if (d == 1) begin
                        if (it.rst) begin
                            b_cnt = 0; b_fr = act[1].frame;
                            if (!it.cen && prev[1].hs && prev[1].vs) begin
                                cmp("midreset_H", 1, act[1].h, 0);
                                cmp("midreset_V", 1, act[1].v, 0);
                                cmp("midreset_HS", 1, act[1].hs, 0);
                                cmp("midreset_VS", 1, act[1].vs, 0);
                                cmp("midreset_LHBL", 1, act[1].lhbl, 1);
                                cmp("midreset_LVBL", 1, act[1].lvbl, 0);
                            end
                        end else if (it.cen) begin
                            b_cnt++;
                            if (prev[1].h == 10'd23 && prev[1].v == 10'd19) begin
                                cmp("lastpix_H", 1, act[1].h, 0);
                                cmp("lastpix_V", 1, act[1].v, 0);
                                cmp("lastpix_LHBL", 1, act[1].lhbl, 1);
                                cmp("lastpix_LVBL", 1, act[1].lvbl, 0);
                                cmp("lastpix_HS", 1, act[1].hs, 0);
                                cmp("lastpix_VS", 1, act[1].vs, 0);
                            end
                            if (act[1].frame !== b_fr) begin
                                cmp("frame_period", 1, b_cnt, 480);
                                b_frames++;
                                b_cnt = 0; b_fr = act[1].frame;
                            end
                        end
                    end
                    if (d == 2 && !act[2].lhbl) c_lb++;
                    prev[d] = act[d];
                end
            end
        end
    end

    // Stimulus
    initial begin
        bit forced = 1'b0;
        bit a;
        bit found;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
        // One line plus a few pixels with a half-rate pixel enable.
        for (int i = 0; i < 2 * 384 + 20; i++) step(i % 2 == 1, 1'b0, 1'b0);
        // Full-rate run: many frames of b/c, about 105 lines of a.
        for (int i = 0; i < 40000; i++) begin
            a = (i % 1000 == 500);
            if (!forced && mh[1] == 23 && mv[1] == 4) begin
                a = 1'b1;
                forced = 1'b1;
            end
            step(1'b1, 1'b0, a);
        end
        found = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (mh[1] == 19 && mv[1] == 16) begin
                found = 1'b1;
                break;
            end
            step(1'b1, 1'b0, 1'b0);
        end
        n_chk++;
        if (!found) begin
            n_err++;
            $display("FAIL midreset_position dut1: got H=%0d V=%0d expected H=19 V=16", mh[1], mv[1]);
        end
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 600; i++) step(i % 3 == 0, 1'b0, i == 500);
        @(posedge clk);
        #3;
        cmp("scoreboard_drained", 0, sb[0].size() + sb[1].size() + sb[2].size(), 0);
        cmp("empty_hblank_low_samples", 2, c_lb, 0);
        cmp("lines_checked_ge_100", 0, (a_lines >= 100) ? 1 : 0, 1);
        cmp("frames_checked_ge_80", 1, (b_frames >= 80) ? 1 : 0, 1);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/jtframe_vidgen.md
Name: jtframe_vidgen

Overview:
- Programmable video timing generator that produces the H/V counters, blanking and sync signals (LHBL, LVBL, HS, VS) for a core.
- Sits directly upstream of the sync re-timing stage. Its HS/VS/LHBL/LVBL outputs feed that stage's hs_in/vs_in/LHBL/LVBL inputs, using the same pxl_cen.
- Everything is clocked on clk and advances only on pxl_cen.

Parameters:
- CNTW, 10, width of the H and V counters (max 1024 pixels/lines).
- HTOTAL, 384, pixels per line; H counts 0..HTOTAL-1.
- HB_START, 256, first H of horizontal blanking.
- HB_END, 0, first H after horizontal blanking; the window may wrap through 0.
- HS_START, 288, first H with HS high.
- HS_END, 320, first H with HS low again.
- VTOTAL, 264, lines per frame; V counts 0..VTOTAL-1.
- VB_START, 240, first line of vertical blanking.
- VB_END, 16, first line after vertical blanking; may wrap.
- VS_START, 244, first line with VS high.
- VS_END, 248, first line with VS low again.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- pxl_cen  in  1  pixel clock enable
- H  out  CNTW  horizontal counter
- V  out  CNTW  vertical counter
- LHBL  out  1  horizontal blank, active low
- LVBL  out  1  vertical blank, active low
- HS  out  1  horizontal sync, active high
- VS  out  1  vertical sync, active high
- frame  out  1  toggles once per frame
- irq_line  in  CNTW  raster interrupt line (feature only)
- irq_ack  in  1  interrupt acknowledge (feature only)
- irq  out  1  raster interrupt request (feature only)

Behaviour:
- Single clock domain, clk. Reset is synchronous and active-high on rst, and it wins over pxl_cen.
- Reset values:
  - H=0, V=0, frame=0, irq=0.
  - LHBL, LVBL, HS and VS are set to their decoded values for H=0, V=0. With the defaults: LHBL=1, LVBL=0, HS=0, VS=0.
- State changes only on clk edges with pxl_cen=1; all outputs hold while pxl_cen=0.
- Counters:
  - If H==HTOTAL-1, H wraps to 0 and V advances; otherwise H increments.
  - V wraps from VTOTAL-1 to 0, and frame toggles on that same edge.
- Window rule, win(c,S,E):
  - If S<E: active when S<=c<E.
  - If S>E (wrap): active when c>=S or c<E.
  - If S==E: never active.
- All status outputs are registered and decoded from the next counter values, so they align with H/V on the same edge (0-cycle skew, no extra latency):
  - LHBL = !win(Hn,HB_START,HB_END)
  - HS = win(Hn,HS_START,HS_END)
  - LVBL = !win(Vn,VB_START,VB_END)
  - VS = win(Vn,VS_START,VS_END)
- Consequence: V-derived outputs change only at the H wrap to 0.
- Simultaneous H and V wrap on the last pixel of the frame: every output takes its H=0, V=0 value on that one edge.
- Reset mid-line or mid-frame restarts cleanly at H=0, V=0 with no partial pulses carried over.
- Parameters must be < 2^CNTW. The window decode uses no arithmetic beyond compares, so there is no overflow path.

Optional Feature:
- Macro: JTFRAME_VIDGEN_IRQ_EN.
- Defined:
  - On the pxl_cen edge where the next position is H=0 and V==irq_line, irq sets to 1.
  - irq stays high until a clk edge with irq_ack=1, which clears it whether or not pxl_cen is set.
  - If set and ack land on the same edge, set wins.
  - irq_line is sampled at that edge. A value >= VTOTAL never fires.
  - rst clears irq.
- Undefined: irq is tied to 0. irq_line and irq_ack are ignored, with no logic generated for them.

Test Plan:
- Reset, then run one full line with defaults and pxl_cen every other clk:
  - LHBL falls as H becomes 256 and rises as H becomes 0.
  - HS is high exactly for H=288..319, i.e. 32 pixels.
  - No output changes on clk edges with pxl_cen=0.
- Run full frames:
  - LVBL is low for V=240..263 and V=0..15 (40 lines), changing only as H goes to 0.
  - VS is high for V=244..247.
  - frame toggles once per 384*264=101376 pxl_cen pulses.
- Last pixel of the frame (H=383, V=263) followed by pxl_cen:
  - H=0, V=0, LHBL=1, LVBL=0, HS=0, VS=0, frame toggled, all on the same edge.
- Assert rst mid-frame at H=300, V=245 (HS=1, VS=1):
  - Next clk gives H=0, V=0, HS=0, VS=0, LHBL=1, LVBL=0, even with pxl_cen=0.
- Override HB_START=10, HB_END=10:
  - LHBL stays 1 for a full frame.
- With JTFRAME_VIDGEN_IRQ_EN and irq_line=100:
  - irq rises as (H,V) becomes (0,100) and holds until irq_ack.
  - With irq_ack asserted on that same rising edge, irq still reads 1 afterwards.
  - With irq_line=300, irq never fires.
